// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard-unit <-> stall-controller bundle: stall/redirect/memory-wait events in,
// pipeline enables/flushes and status back out.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned STALL_W = 4
);
  logic               stall_req;
  logic               branch_taken;
  logic               imem_wait;
  logic               dmem_wait;
  logic               PC_Write;
  logic               IFID_Write;
  logic               IFID_Flush;
  logic               IDEX_Flush;
  logic               IDEX_Stall;
  logic [31:0]        flag;
  logic [STALL_W-1:0] stall_cnt;
  logic               stall_timeout;
  logic [1:0]         ctrl_state;

  modport master (
    output stall_req, branch_taken, imem_wait, dmem_wait,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
    input  IDEX_Stall, flag, stall_cnt, stall_timeout, ctrl_state
  );

  modport slave (
    input  stall_req, branch_taken, imem_wait, dmem_wait,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush,
    output IDEX_Stall, flag, stall_cnt, stall_timeout, ctrl_state
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall controller: resolves memory-wait, branch redirect and load-use
// stall into PC/IF-ID/ID-EX enables and flushes, and tracks stall status.
module pipeline_stall_ctrl #(
  parameter int unsigned MAX_STALL = 8,
  parameter int unsigned STALL_W   = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam int unsigned FLAG_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_MWAIT    = 2'd3
  } state_e;

  logic               idex_stall_q, idex_stall_d;
  logic [FLAG_W-1:0]  flag_q, flag_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               stall_timeout_q, stall_timeout_d;
  state_e             ctrl_state_q, ctrl_state_d;

  state_e             act;
  logic               mw;
  logic [STALL_W-1:0] cnt_sat;
  logic               pc_write, ifid_write, ifid_flush, idex_flush;

  assign mw = bus.imem_wait | bus.dmem_wait;

  // Priority resolution; flag==0 masks stall_req in the first cycle out of reset.
  always_comb begin
    act = ST_RUN;
    if (mw)                                      act = ST_MWAIT;
    else if (bus.branch_taken)                   act = ST_REDIRECT;
    else if (bus.stall_req && (flag_q != '0))    act = ST_BUBBLE;
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      case (act)
        ST_MWAIT: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
        end
        ST_REDIRECT: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end
        ST_BUBBLE: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_sat = (stall_cnt_q >= STALL_W'(MAX_STALL)) ? STALL_W'(MAX_STALL)
                                                   : stall_cnt_q + STALL_W'(1);
  end

  // Next-state for all status registers; reset has top priority.
  always_comb begin
    idex_stall_d    = idex_stall_q;
    flag_d          = flag_q;
    stall_cnt_d     = stall_cnt_q;
    stall_timeout_d = stall_timeout_q;
    ctrl_state_d    = ctrl_state_q;
    if (rst) begin
      idex_stall_d    = 1'b0;
      flag_d          = '0;
      stall_cnt_d     = '0;
      stall_timeout_d = 1'b0;
      ctrl_state_d    = ST_RUN;
    end else begin
      if (flag_q != {FLAG_W{1'b1}}) flag_d = flag_q + FLAG_W'(1);
      ctrl_state_d = act;
      case (act)
        ST_MWAIT: ;
        ST_BUBBLE: begin
          idex_stall_d = 1'b1;
          stall_cnt_d  = cnt_sat;
          if (cnt_sat == STALL_W'(MAX_STALL)) stall_timeout_d = 1'b1;
        end
        default: begin
          idex_stall_d = 1'b0;
          stall_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    idex_stall_q    <= idex_stall_d;
    flag_q          <= flag_d;
    stall_cnt_q     <= stall_cnt_d;
    stall_timeout_q <= stall_timeout_d;
    ctrl_state_q    <= ctrl_state_d;
  end

  assign bus.PC_Write      = pc_write;
  assign bus.IFID_Write    = ifid_write;
  assign bus.IFID_Flush    = ifid_flush;
  assign bus.IDEX_Flush    = idex_flush;
  assign bus.IDEX_Stall    = idex_stall_q;
  assign bus.flag          = flag_q;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.stall_timeout = stall_timeout_q;
  assign bus.ctrl_state    = ctrl_state_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: hand-computed expectations checked with
// immediate assertions at each step.
module tb_pipeline_stall_ctrl;
  localparam int unsigned STALL_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_flag = '0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.STALL_W(STALL_W)) bus_if ();

  pipeline_stall_ctrl #(.MAX_STALL(8), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1ns later; bench tracks the expected cycle counter.
  task automatic step();
    @(posedge clk);
    if (rst) exp_flag = '0;
    else if (exp_flag != 32'hFFFF_FFFF) exp_flag = exp_flag + 32'd1;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, bus_if.PC_Write, bus_if.IFID_Write, bus_if.IFID_Flush, bus_if.IDEX_Flush},
        {28'd0, exp});
  endtask

  task automatic chk_regs(input string tag, input logic stl, input logic [3:0] cnt,
                          input logic tmo, input logic [1:0] st);
    chk({tag, "_flag"},  bus_if.flag, exp_flag);
    chk({tag, "_stall"}, {31'd0, bus_if.IDEX_Stall}, {31'd0, stl});
    chk({tag, "_cnt"},   {28'd0, bus_if.stall_cnt}, {28'd0, cnt});
    chk({tag, "_tmo"},   {31'd0, bus_if.stall_timeout}, {31'd0, tmo});
    chk({tag, "_state"}, {30'd0, bus_if.ctrl_state}, {30'd0, st});
  endtask

  initial begin
    bus_if.stall_req    = 1'b0;
    bus_if.branch_taken = 1'b0;
    bus_if.imem_wait    = 1'b0;
    bus_if.dmem_wait    = 1'b0;

    // Reset state and forced combinational outputs
    step(); step();
    chk_comb("rst_comb", 4'b0011);
    chk_regs("rst", 1'b0, 4'd0, 1'b0, 2'd0);

    // Release with stall_req held: first cycle (flag=0) ignores it
    rst = 1'b0; bus_if.stall_req = 1'b1; #1;
    chk_comb("flag0_run", 4'b1100);
    step();
    chk_regs("c1", 1'b0, 4'd0, 1'b0, 2'd0);
    chk_comb("c1_bubble", 4'b0001);
    step();
    chk_regs("c2", 1'b1, 4'd1, 1'b0, 2'd1);
    bus_if.stall_req = 1'b0; #1;
    chk_comb("c2_run", 4'b1100);
    step();
    chk_regs("c3", 1'b0, 4'd0, 1'b0, 2'd0);

    // Single load-use stall at flag=10
    repeat (7) step();
    chk("flag10", bus_if.flag, 32'd10);
    bus_if.stall_req = 1'b1; #1;
    chk_comb("lu_comb", 4'b0001);
    step();
    chk_regs("lu1", 1'b1, 4'd1, 1'b0, 2'd1);
    bus_if.stall_req = 1'b0;
    step();
    chk_regs("lu2", 1'b0, 4'd0, 1'b0, 2'd0);

    // Redirect beats stall and clears IDEX_Stall
    bus_if.stall_req = 1'b1;
    step();
    chk_regs("pre_br", 1'b1, 4'd1, 1'b0, 2'd1);
    bus_if.branch_taken = 1'b1; #1;
    chk_comb("br_comb", 4'b1111);
    step();
    chk_regs("br", 1'b0, 4'd0, 1'b0, 2'd2);

    // Memory wait freezes everything over both other requests
    bus_if.branch_taken = 1'b0;
    step(); step();
    chk_regs("pre_mw", 1'b1, 4'd2, 1'b0, 2'd1);
    bus_if.dmem_wait = 1'b1; bus_if.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_comb("mw_comb", 4'b0000);
      step();
      chk_regs("mw", 1'b1, 4'd2, 1'b0, 2'd3);
    end
    bus_if.dmem_wait = 1'b0; bus_if.branch_taken = 1'b0; bus_if.stall_req = 1'b0;
    bus_if.imem_wait = 1'b1; #1;
    chk_comb("imw_comb", 4'b0000);
    bus_if.imem_wait = 1'b0;
    step();
    chk_regs("post_mw", 1'b0, 4'd0, 1'b0, 2'd0);

    // Long stall: count saturates at 8, timeout sticky
    bus_if.stall_req = 1'b1;
    repeat (7) step();
    chk_regs("ls7", 1'b1, 4'd7, 1'b0, 2'd1);
    step();
    chk_regs("ls8", 1'b1, 4'd8, 1'b1, 2'd1);
    step(); step();
    chk_regs("ls10", 1'b1, 4'd8, 1'b1, 2'd1);
    bus_if.stall_req = 1'b0;
    step();
    chk_regs("ls_drop", 1'b0, 4'd0, 1'b1, 2'd0);

    // Mid-operation reset overrides an active redirect
    bus_if.branch_taken = 1'b1;
    rst = 1'b1; #1;
    chk_comb("rst2_comb", 4'b0011);
    step();
    chk_regs("rst2", 1'b0, 4'd0, 1'b0, 2'd0);
    bus_if.branch_taken = 1'b0;
    rst = 1'b0;

    // Saturation of the cycle counter
    force dut.flag_q = 32'hFFFF_FFFE;
    #1;
    release dut.flag_q;
    exp_flag = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flag_sat", bus_if.flag, 32'hFFFF_FFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Consumes the load-use/branch stall request from the hazard detection logic, plus branch-redirect and memory-wait events.
- Drives the pipeline enables and flushes: PC write, IF/ID write/flush, ID/EX bubble.
- Generates the two status signals the hazard logic reads back: IDEX_Stall (bubble inserted last cycle) and flag (cycles since reset; 0 disables stall detection).
- Sits between the hazard detection unit and the PC / IF-ID / ID-EX pipeline registers.

Parameters:
- MAX_STALL, 8: consecutive stall-request cycles that trips the sticky stall_timeout error.
- STALL_W, 4: stall_cnt width; must satisfy 2^STALL_W > MAX_STALL.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- stall_req  input  1  stall request from hazard detection unit
- branch_taken  input  1  EX-stage redirect (taken branch/jump) this cycle
- imem_wait  input  1  instruction memory not ready
- dmem_wait  input  1  data memory not ready
- PC_Write  output  1  PC register load enable (combinational)
- IFID_Write  output  1  IF/ID register load enable (combinational)
- IFID_Flush  output  1  IF/ID load NOP/invalid (combinational)
- IDEX_Flush  output  1  ID/EX load bubble (combinational)
- IDEX_Stall  output  1  registered: 1 when previous accepted cycle inserted a load-use bubble
- flag  output  32  registered cycle counter since reset, saturating
- stall_cnt  output  STALL_W  registered consecutive-stall count, saturating at MAX_STALL
- stall_timeout  output  1  registered sticky error
- ctrl_state  output  2  registered last action: 0 RUN, 1 BUBBLE, 2 REDIRECT, 3 MWAIT

Behaviour:
- Reset values (while rst=1, effective next edge): IDEX_Stall=0, flag=0, stall_cnt=0, stall_timeout=0, ctrl_state=RUN.
- While rst=1, combinational outputs are forced: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Flush=1.
- Reset mid-operation overrides every other input.
- mw = imem_wait | dmem_wait. Per-cycle action, priority high→low:
  1. MWAIT (mw=1): PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Flush=0. Whole pipeline frozen; branch_taken and stall_req ignored this cycle. IDEX_Stall and stall_cnt hold. ctrl_state←MWAIT.
  2. REDIRECT (branch_taken=1): PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEX_Flush=1. stall_req ignored. IDEX_Stall←0, stall_cnt←0, ctrl_state←REDIRECT.
  3. BUBBLE (stall_req=1 and flag≠0): PC_Write=0, IFID_Write=0, IFID_Flush=0, IDEX_Flush=1. IDEX_Stall←1, ctrl_state←BUBBLE. stall_cnt←min(stall_cnt+1, MAX_STALL).
  4. RUN (otherwise, including stall_req=1 with flag=0): PC_Write=1, IFID_Write=1, both flushes 0. IDEX_Stall←0, stall_cnt←0, ctrl_state←RUN.
- Combinational outputs depend only on current inputs, current flag, and rst; zero-cycle latency from stall_req/branch_taken/mw.
- flag increments by 1 every non-reset cycle, including MWAIT. Saturates at 0xFFFFFFFF (no wrap). flag=0 only in the first cycle after reset release, so stall_req is ignored in exactly that cycle.
- stall_timeout←1 on the edge where a BUBBLE cycle makes stall_cnt reach MAX_STALL. Stays 1 until rst.
- stall_cnt stays at MAX_STALL while further BUBBLE cycles occur.
- IDEX_Stall is 1 for exactly the cycle after each BUBBLE cycle; back-to-back BUBBLEs keep it 1.
- Simultaneous events resolve strictly by the priority list; no event is queued or remembered. A stall_req dropped by REDIRECT or MWAIT must be re-asserted by the hazard unit.

Test Plan:
- Reset release, stall_req=1 held: cycle 0 after reset (flag=0) gives PC_Write=1, IDEX_Flush=0. Cycle 1 (flag=1) gives PC_Write=0, IFID_Write=0, IDEX_Flush=1; IDEX_Stall=1 in cycle 2.
- Single load-use stall, stall_req=1 for one cycle at flag=10: one BUBBLE, IDEX_Stall=1 for one cycle, stall_cnt 0→1→0, ctrl_state 0→1→0.
- stall_req and branch_taken both 1: IFID_Flush=1, IDEX_Flush=1, PC_Write=1, IDEX_Stall←0, ctrl_state=2.
- dmem_wait=1 for 3 cycles with stall_req=1 and branch_taken=1: all four combinational outputs 0 for 3 cycles, IDEX_Stall/stall_cnt unchanged, flag +3, ctrl_state=3.
- stall_req held 10 cycles (MAX_STALL=8): stall_cnt saturates at 8, stall_timeout rises after the 8th BUBBLE and stays 1 after stall_req drops; rst=1 clears all registers next edge.
- Force flag to 0xFFFFFFFE, run 3 cycles: flag reads 0xFFFFFFFF and holds (no wrap).
